multi_cycle_ctrl: RTL and testbench
===================================

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 The block SHALL have the port opcode, input, 6 bits: instruction bits [31:26], sampled in DECODE.
REQ-004 The block SHALL have the port funct, input, 6 bits: instruction bits [5:0], used for R-type.
REQ-005 The block SHALL have the port zero, input, 1 bit: the ALU Zero flag, sampled in EXEC of beq.
REQ-006 The block SHALL have the port mem_ready, input, 1 bit: the memory access completes this cycle.
REQ-007 The block SHALL have the port ALUOp, output, 3 bits: 000 add, 001 sub, 010 xor, 011 nor, 100 or.
REQ-008 The block SHALL have the port ALUSrc, output, 1 bit: 1 selects imm_ext as ALU B, 0 selects register B.
REQ-009 The block SHALL have the ports ir_write, pc_write, mem_read, mem_write, reg_write, reg_dst, mem_to_reg and illegal, outputs, 1 bit each: datapath strobes.
REQ-010 The block SHALL have the port retired, output, 32 bits: count of retired instructions; present only under CTRL_PERF_CNT_EN.

Function
REQ-011 The block SHALL implement the states FETCH, DECODE, EXEC, MEM and WB.
REQ-012 In FETCH the block SHALL assert mem_read, and SHALL remain in FETCH while mem_ready=0.
REQ-013 In FETCH, when mem_ready=1, the block SHALL pulse ir_write and pc_write for one cycle, drive ALUOp=000 and ALUSrc=1 (PC+4), then go to DECODE.
REQ-014 In DECODE the block SHALL classify the instruction: R-type (000000), addi (001000), ori (001101), xori (001110), lw (100011), sw (101011), beq (000100); it SHALL then go to EXEC.
REQ-015 An unlisted opcode, or an R-type funct other than add 100000 / sub 100010 / xor 100110 / nor 100111 / or 100101, SHALL pulse illegal for one cycle in DECODE, return to FETCH, assert no write strobe and not count as retired.
REQ-016 In EXEC the block SHALL drive the following ALUOp and ALUSrc values:
- R-type: ALUOp from funct, ALUSrc=0
- addi, lw, sw: ALUOp 000, ALUSrc=1
- ori: ALUOp 100, ALUSrc=1
- xori: ALUOp 010, ALUSrc=1
- beq: ALUOp 001, ALUSrc=0
REQ-017 For beq, EXEC SHALL pulse pc_write only if zero=1, then return to FETCH; beq retires there.
REQ-018 After EXEC, lw and sw SHALL go to MEM; R-type and immediate ALU instructions SHALL go to WB.
REQ-019 MEM SHALL assert mem_read for lw or mem_write for sw, and SHALL hold ALUOp and ALUSrc stable while mem_ready=0.
REQ-020 On mem_ready=1, MEM SHALL go to WB for lw, or to FETCH for sw; sw retires there.
REQ-021 WB SHALL pulse reg_write for one cycle, with reg_dst=1 for R-type only and mem_to_reg=1 for lw only, then go to FETCH.
REQ-022 Latency, with mem_ready tied high: R-type and immediate 4 cycles, lw 5, sw 4, beq 3.
REQ-023 Outside the states above, ALUOp SHALL be 000, ALUSrc 0 and every strobe 0; outputs SHALL be registered from state, and the instruction class SHALL be latched in DECODE.

Reset
REQ-024 While rst_n=0, the block SHALL force state FETCH, ALUOp 000, ALUSrc 0, all strobes 0 and retired 0.
REQ-025 A reset mid-instruction SHALL abandon the instruction with no write strobe; the first cycle after release SHALL be FETCH.

Configuration
REQ-026 With CTRL_PERF_CNT_EN defined, retired SHALL increment by 1 per retired instruction and wrap from 0xFFFFFFFF to 0.
REQ-027 Without CTRL_PERF_CNT_EN, the retired port and its counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-028 Package ctrl_pkg SHALL hold the opcode and funct constants, the ALUOp encodings, the state enum and the instruction-class enum.
REQ-029 The combinational funct-to-ALUOp map SHALL be the sub-module alu_op_decoder; the FSM SHALL remain in multi_cycle_ctrl.

Verification
REQ-030 The bench SHALL cover: add R-type (funct 100000), mem_ready=1 -> ALUOp 000, ALUSrc 0 in EXEC, reg_write and reg_dst in cycle 4.
REQ-031 The bench SHALL cover: lw with mem_ready low for 3 MEM cycles -> mem_read held 4 cycles, then WB with mem_to_reg=1, total 8 cycles.
REQ-032 The bench SHALL cover: beq with zero=1 -> pc_write pulses in EXEC; beq with zero=0 -> no pc_write; both return to FETCH at cycle 4.
REQ-033 The bench SHALL cover: opcode 111111 -> illegal pulse in DECODE, no write strobes, FETCH next, retired unchanged.
REQ-034 The bench SHALL cover: rst_n low during MEM of sw -> mem_write drops immediately, and no write occurs after release.
REQ-035 The bench SHALL cover, with CTRL_PERF_CNT_EN defined: retired preset near 0xFFFFFFFF, then 2 instructions -> retired wraps to 0x00000000.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared constants and types for the multi-cycle controller:
// opcode/funct codes, ALU op encodings, FSM state and instruction class.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_OR  = 6'b100101;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_NOR = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
    } state_t;

    typedef enum logic [2:0] {
        CL_R, CL_ADDI, CL_ORI, CL_XORI,
        CL_LW, CL_SW, CL_BEQ, CL_ILL
    } iclass_t;

    function automatic iclass_t classify(input logic [5:0] op);
        iclass_t c;
        unique case (1'b1)
            (op == OP_RTYPE): c = CL_R;
            (op == OP_ADDI):  c = CL_ADDI;
            (op == OP_ORI):   c = CL_ORI;
            (op == OP_XORI):  c = CL_XORI;
            (op == OP_LW):    c = CL_LW;
            (op == OP_SW):    c = CL_SW;
            (op == OP_BEQ):   c = CL_BEQ;
            default:          c = CL_ILL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multi_cycle_ctrl_alu_op_decoder.sv
// R-type funct to ALU op map.
// Ports: funct (in), alu_op (out), valid (out, 0 for unsupported funct).
module alu_op_decoder
    import ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       valid
);

    always_comb begin
        alu_op = ALU_ADD;
        valid  = 1'b1;
        unique case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_XOR:  alu_op = ALU_XOR;
            FN_NOR:  alu_op = ALU_NOR;
            FN_OR:   alu_op = ALU_OR;
            default: valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller.
// In: clk, rst_n (async, low), opcode, funct, zero, mem_ready.
// Out: ALUOp, ALUSrc, ir_write, pc_write, mem_read, mem_write,
// reg_write, reg_dst, mem_to_reg, illegal; retired when the
// CTRL_PERF_CNT_EN macro is defined (retired-instruction counter).
module multi_cycle_ctrl
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [2:0] ALUOp,
    output logic       ALUSrc,
    output logic       ir_write,
    output logic       pc_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0] retired
`endif
);

    state_t     state_q, state_d;
    iclass_t    cls_q, cls_d;
    logic [2:0] rop_q, rop_d;
    logic       fn_ok, ill_d;

    alu_op_decoder u_dec (
        .funct  (funct),
        .alu_op (rop_d),
        .valid  (fn_ok)
    );

    assign cls_d = classify(opcode);
    assign ill_d = (cls_d == CL_ILL) || ((cls_d == CL_R) && !fn_ok);

    // State register; class and R-type ALU op latched in DECODE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cls_q   <= CL_ILL;
            rop_q   <= ALU_ADD;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                cls_q <= cls_d;
                rop_q <= rop_d;
            end
        end
    end

    always_comb begin
        state_d = S_FETCH;
        unique case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: state_d = ill_d ? S_FETCH : S_EXEC;
            S_EXEC: begin
                if (cls_q == CL_BEQ)
                    state_d = S_FETCH;
                else if (cls_q == CL_LW || cls_q == CL_SW)
                    state_d = S_MEM;
                else
                    state_d = S_WB;
            end
            S_MEM: begin
                if (!mem_ready)
                    state_d = S_MEM;
                else if (cls_q == CL_LW)
                    state_d = S_WB;
                else
                    state_d = S_FETCH;
            end
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Outputs decode the registered state; gating on rst_n keeps
    // every strobe low for the whole reset, not just after an edge.
    always_comb begin
        ALUOp      = ALU_ADD;
        ALUSrc     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                S_FETCH: begin
                    mem_read = 1'b1;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                    ALUSrc   = mem_ready;
                end
                S_DECODE: illegal = ill_d;
                S_EXEC: begin
                    unique case (cls_q)
                        CL_R:    ALUOp = rop_q;
                        CL_ORI:  begin ALUOp = ALU_OR;  ALUSrc = 1'b1; end
                        CL_XORI: begin ALUOp = ALU_XOR; ALUSrc = 1'b1; end
                        CL_BEQ: begin
                            ALUOp    = ALU_SUB;
                            pc_write = zero;
                        end
                        CL_ADDI, CL_LW, CL_SW: ALUSrc = 1'b1;
                        default: ;
                    endcase
                end
                S_MEM: begin
                    // Address stays on the ALU while memory stalls
                    ALUSrc    = 1'b1;
                    mem_read  = (cls_q == CL_LW);
                    mem_write = (cls_q == CL_SW);
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = (cls_q == CL_R);
                    mem_to_reg = (cls_q == CL_LW);
                end
                default: ;
            endcase
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic        retire;
    logic [31:0] retired_q;

    assign retire = (state_q == S_WB)
        || (state_q == S_EXEC && cls_q == CL_BEQ)
        || (state_q == S_MEM && cls_q == CL_SW && mem_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retired_q <= '0;
        else if (retire)
            retired_q <= retired_q + 32'd1;
    end

    assign retired = retired_q;
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl.
// Per-cycle expected outputs go through a scoreboard queue.
module tb_multi_cycle_ctrl;
    import ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic [2:0] ALUOp;
    logic       ALUSrc, ir_write, pc_write, mem_read, mem_write;
    logic       reg_write, reg_dst, mem_to_reg, illegal;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] retired;
`endif

    multi_cycle_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .ALUOp      (ALUOp),
        .ALUSrc     (ALUSrc),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .illegal    (illegal)
`ifdef CTRL_PERF_CNT_EN
        ,
        .retired    (retired)
`endif
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] n_ret = '0;
    logic [11:0] exp_q[$];

    wire [11:0] obs = {ALUOp, ALUSrc, ir_write, pc_write, mem_read,
                       mem_write, reg_write, reg_dst, mem_to_reg, illegal};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] ov(
        input logic [2:0] aop, input logic src, input logic irw,
        input logic pcw, input logic mrd, input logic mwr,
        input logic rw, input logic rd, input logic m2r, input logic ill);
        return {aop, src, irw, pcw, mrd, mwr, rw, rd, m2r, ill};
    endfunction

    localparam logic [11:0] NONE   = 12'd0;
    localparam logic [11:0] F_GO   = {ALU_ADD, 9'b1_1110_0000};
    localparam logic [11:0] F_IDLE = {ALU_ADD, 9'b0_0010_0000};
    localparam logic [11:0] WB_I   = {ALU_ADD, 9'b0_0000_1000};

    // Called just after a falling edge: drive, push, compare, advance
    task automatic cyc(input string tag, input logic [5:0] op,
                       input logic [5:0] fn, input logic z,
                       input logic mr, input logic [11:0] e);
        opcode    = op;
        funct     = fn;
        zero      = z;
        mem_ready = mr;
        exp_q.push_back(e);
        #1;
        check(tag, {20'd0, obs}, {20'd0, exp_q.pop_front()});
        @(negedge clk);
    endtask

    task automatic chk_ret(input string tag);
`ifdef CTRL_PERF_CNT_EN
        check(tag, retired, n_ret);
`else
        n_ret = n_ret;
`endif
    endtask

    logic [5:0] r_fn[5]  = '{FN_ADD, FN_SUB, FN_XOR, FN_NOR, FN_OR};
    logic [2:0] r_aop[5] = '{ALU_ADD, ALU_SUB, ALU_XOR, ALU_NOR, ALU_OR};
    logic [5:0] i_op[3]  = '{OP_ADDI, OP_ORI, OP_XORI};
    logic [2:0] i_aop[3] = '{ALU_ADD, ALU_OR, ALU_XOR};

    initial begin
        #2;
        check("rst_out", {20'd0, obs}, 32'd0);
        chk_ret("rst_ret");
        @(negedge clk);
        check("rst_hold", {20'd0, obs}, 32'd0);
        rst_n = 1'b1;

        // R-type; opcode/funct scrambled after DECODE to test latching
        for (int i = 0; i < 5; i++) begin
            cyc("r_fetch", OP_RTYPE, r_fn[i], 0, 1, F_GO);
            cyc("r_dec", OP_RTYPE, r_fn[i], 0, 1, NONE);
            cyc("r_exec", 6'h3f, 6'h00, 0, 1,
                ov(r_aop[i], 0, 0, 0, 0, 0, 0, 0, 0, 0));
            cyc("r_wb", 6'h3f, 6'h00, 0, 1,
                ov(ALU_ADD, 0, 0, 0, 0, 0, 1, 1, 0, 0));
            n_ret++;
        end
        cyc("r_idle", 6'h3f, 6'h00, 0, 0, F_IDLE);
        chk_ret("r_ret");

        for (int i = 0; i < 3; i++) begin
            cyc("i_fetch", i_op[i], 6'h00, 0, 1, F_GO);
            cyc("i_dec", i_op[i], 6'h00, 0, 1, NONE);
            cyc("i_exec", 6'h00, 6'h3f, 0, 1,
                ov(i_aop[i], 1, 0, 0, 0, 0, 0, 0, 0, 0));
            cyc("i_wb", 6'h00, 6'h3f, 0, 1, WB_I);
            n_ret++;
        end

        // lw with three stalled MEM cycles: 8 cycles in total
        cyc("lw_fetch", OP_LW, 6'h00, 0, 1, F_GO);
        cyc("lw_dec", OP_LW, 6'h00, 0, 1, NONE);
        cyc("lw_exec", 6'h3f, 6'h00, 0, 1,
            ov(ALU_ADD, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++)
            cyc("lw_mem", 6'h3f, 6'h00, 0, (i == 3),
                ov(ALU_ADD, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        cyc("lw_wb", 6'h3f, 6'h00, 0, 0,
            ov(ALU_ADD, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        n_ret++;
        cyc("lw_next", 6'h3f, 6'h00, 0, 0, F_IDLE);
        chk_ret("lw_ret");

        cyc("sw_fetch", OP_SW, 6'h00, 0, 1, F_GO);
        cyc("sw_dec", OP_SW, 6'h00, 0, 1, NONE);
        cyc("sw_exec", 6'h3f, 6'h00, 0, 1,
            ov(ALU_ADD, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc("sw_mem", 6'h3f, 6'h00, 0, 1,
            ov(ALU_ADD, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        n_ret++;
        cyc("sw_next", 6'h3f, 6'h00, 0, 0, F_IDLE);
        chk_ret("sw_ret");

        for (int z = 1; z >= 0; z--) begin
            cyc("beq_fetch", OP_BEQ, 6'h00, 0, 1, F_GO);
            cyc("beq_dec", OP_BEQ, 6'h00, 0, 1, NONE);
            cyc("beq_exec", 6'h3f, 6'h00, z[0], 1,
                ov(ALU_SUB, 0, 0, z[0], 0, 0, 0, 0, 0, 0));
            n_ret++;
            cyc("beq_next", 6'h3f, 6'h00, 0, 0, F_IDLE);
        end
        chk_ret("beq_ret");

        cyc("ill_fetch", 6'h3f, 6'h00, 0, 1, F_GO);
        cyc("ill_dec", 6'h3f, 6'h00, 0, 1,
            ov(ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        cyc("ill_next", 6'h3f, 6'h00, 0, 0, F_IDLE);
        cyc("illf_fetch", OP_RTYPE, 6'h21, 0, 1, F_GO);
        cyc("illf_dec", OP_RTYPE, 6'h21, 0, 1,
            ov(ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        cyc("illf_next", OP_RTYPE, 6'h21, 0, 0, F_IDLE);
        chk_ret("ill_ret");

        // Reset while sw stalls in MEM
        cyc("rs_fetch", OP_SW, 6'h00, 0, 1, F_GO);
        cyc("rs_dec", OP_SW, 6'h00, 0, 1, NONE);
        cyc("rs_exec", 6'h3f, 6'h00, 0, 0,
            ov(ALU_ADD, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc("rs_mem", 6'h3f, 6'h00, 0, 0,
            ov(ALU_ADD, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        #1;
        rst_n = 1'b0;
        #1;
        check("rs_drop", {20'd0, obs}, 32'd0);
        @(negedge clk);
        check("rs_hold", {20'd0, obs}, 32'd0);
        rst_n = 1'b1;
        n_ret = '0;
        cyc("rs_rel0", 6'h3f, 6'h00, 0, 0, F_IDLE);
        cyc("rs_rel1", 6'h3f, 6'h00, 0, 0, F_IDLE);
        chk_ret("rs_ret");

`ifdef CTRL_PERF_CNT_EN
        #1;
        force dut.retired_q = 32'hFFFF_FFFE;
        #1;
        release dut.retired_q;
        n_ret = 32'hFFFF_FFFE;
        cyc("wr_fetch", OP_BEQ, 6'h00, 0, 1, F_GO);
        cyc("wr_dec", OP_BEQ, 6'h00, 0, 1, NONE);
        cyc("wr_exec", 6'h3f, 6'h00, 0, 1,
            ov(ALU_SUB, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        n_ret++;
        chk_ret("wr_ret1");
        cyc("wr2_fetch", OP_ADDI, 6'h00, 0, 1, F_GO);
        cyc("wr2_dec", OP_ADDI, 6'h00, 0, 1, NONE);
        cyc("wr2_exec", 6'h3f, 6'h00, 0, 1,
            ov(ALU_ADD, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc("wr2_wb", 6'h3f, 6'h00, 0, 1, WB_I);
        n_ret++;
        cyc("wr_idle", 6'h3f, 6'h00, 0, 0, F_IDLE);
        chk_ret("wr_ret0");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
